// File: rtl/stepper_driver_pkg.sv
// Shared definitions for the paper-feed stepper driver and its monitor-side decoder.
// The half-step table lives here so driver and decoder can never disagree.
package stepper_pkg;

  typedef logic [2:0] step_t;

  typedef struct packed {
    logic a;
    logic b;
    logic na;
    logic nb;
  } phases_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINISH
  } state_t;

  localparam int HALF_STEPS_PER_LINE = 4;

  // Half-step sequence: single and double phase energisation alternate.
  function automatic phases_t step_to_phases(step_t s);
    phases_t p;
    case (s)
      3'd0:    p = phases_t'(4'b1000);
      3'd1:    p = phases_t'(4'b1100);
      3'd2:    p = phases_t'(4'b0100);
      3'd3:    p = phases_t'(4'b0110);
      3'd4:    p = phases_t'(4'b0010);
      3'd5:    p = phases_t'(4'b0011);
      3'd6:    p = phases_t'(4'b0001);
      default: p = phases_t'(4'b1001);
    endcase
    return p;
  endfunction

endpackage

// File: rtl/stepper_driver_if.sv
// Command channel of the stepper driver: one line-move command per valid/ready handshake.
interface stepper_driver_if #(
  parameter int LINE_W   = 16,
  parameter int PERIOD_W = 24
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_reverse;
  logic [LINE_W-1:0]   cmd_lines;
  logic [PERIOD_W-1:0] step_period;

  modport master (
    output cmd_valid,
    output cmd_reverse,
    output cmd_lines,
    output step_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_reverse,
    input  cmd_lines,
    input  step_period,
    output cmd_ready
  );

endinterface

// File: rtl/stepper_driver_encoder.sv
// Turns a step index into registered phase drives; de-energise forces all phases off.
import stepper_pkg::*;

module stepper_encoder (
  input  logic    clk,
  input  logic    reset,
  input  step_t   i_index,
  input  logic    i_deEnergise,
  output phases_t o_phases
);

  phases_t r_phases;

  // Register the table lookup so the phase pins change cleanly on a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phases <= '0;
    end else if (i_deEnergise) begin
      r_phases <= '0;
    end else begin
      r_phases <= step_to_phases(i_index);
    end
  end

  assign o_phases = r_phases;

endmodule

// File: rtl/stepper_driver.sv
// Paper-feed stepper driver: accepts line-move commands and walks the half-step
// sequence at a fixed period, four half-steps per dot line, with per-line ticks.
import stepper_pkg::*;

module stepper_driver #(
  parameter int LINE_W   = 16,
  parameter int PERIOD_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  stepper_driver_if.slave   cmd,
  input  logic              energise,
  input  logic              abort,
  output logic              motor_phase_a,
  output logic              motor_phase_b,
  output logic              motor_phase_na,
  output logic              motor_phase_nb,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              line_advance_tick,
  output logic              line_reverse_tick
);

  state_t              r_state, w_stateNext;
  step_t               r_index, w_indexNext;
  logic                r_reverse;
  logic [LINE_W-1:0]   r_lines;
  logic [PERIOD_W-1:0] r_period, r_timer, w_periodSafe;
  logic [1:0]          r_halfCnt;
  logic                w_accept, w_step, w_lineDone, w_deEnergise;
  logic                r_cmdReady, r_busy, r_done, r_aborted, r_tickAdv, r_tickRev;
  logic                w_readyNext, w_busyNext, w_doneNext, w_abortedNext;
  logic                w_tickAdvNext, w_tickRevNext;
  phases_t             w_phases;

  assign w_accept     = (r_state == ST_IDLE) && cmd.cmd_valid && r_cmdReady;
  assign w_periodSafe = (cmd.step_period == '0) ? PERIOD_W'(1) : cmd.step_period;
  assign w_step       = (r_state == ST_RUN) && !abort && (r_timer == PERIOD_W'(1));
  assign w_lineDone   = w_step && (r_halfCnt == 2'(HALF_STEPS_PER_LINE - 1));
  assign w_deEnergise = (w_stateNext == ST_IDLE) && !energise;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: abort beats a coincident step; the last line's final half-step ends the move.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_stateNext = (cmd.cmd_lines == '0) ? ST_FINISH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_stateNext = ST_IDLE;
        end else if (w_lineDone && (r_lines == LINE_W'(1))) begin
          w_stateNext = ST_FINISH;
        end
      end
      ST_FINISH: w_stateNext = ST_IDLE;
      default:   w_stateNext = ST_IDLE;
    endcase
  end

  // Step index moves one position per half-step, wrapping modulo 8 in either direction.
  always_comb begin
    w_indexNext = r_index;
    if (w_step) begin
      w_indexNext = r_reverse ? (r_index - step_t'(1)) : (r_index + step_t'(1));
    end
  end

  // Command latch, step timer and line bookkeeping; latched values isolate the move from input changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_index   <= '0;
      r_reverse <= 1'b0;
      r_lines   <= '0;
      r_period  <= '0;
      r_timer   <= '0;
      r_halfCnt <= '0;
    end else begin
      r_index <= w_indexNext;
      if (w_accept) begin
        r_reverse <= cmd.cmd_reverse;
        r_lines   <= cmd.cmd_lines;
        r_period  <= w_periodSafe;
        r_timer   <= w_periodSafe;
        r_halfCnt <= '0;
      end else if ((r_state == ST_RUN) && !abort) begin
        if (r_timer == PERIOD_W'(1)) begin
          r_timer   <= r_period;
          r_halfCnt <= r_halfCnt + 2'd1;
          if (w_lineDone) begin
            r_lines <= r_lines - LINE_W'(1);
          end
        end else begin
          r_timer <= r_timer - PERIOD_W'(1);
        end
      end
    end
  end

  // Next values of the status outputs, derived from where the FSM is heading.
  always_comb begin
    w_readyNext   = (w_stateNext == ST_IDLE);
    w_busyNext    = (w_stateNext == ST_RUN);
    w_doneNext    = (r_state == ST_FINISH);
    w_abortedNext = (r_state == ST_RUN) && abort;
    w_tickAdvNext = w_lineDone && !r_reverse;
    w_tickRevNext = w_lineDone && r_reverse;
  end

  // Status outputs are registered so they line up with the registered phase drives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmdReady <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_tickAdv  <= 1'b0;
      r_tickRev  <= 1'b0;
    end else begin
      r_cmdReady <= w_readyNext;
      r_busy     <= w_busyNext;
      r_done     <= w_doneNext;
      r_aborted  <= w_abortedNext;
      r_tickAdv  <= w_tickAdvNext;
      r_tickRev  <= w_tickRevNext;
    end
  end

  stepper_encoder u_encoder (
    .clk          (clk),
    .reset        (reset),
    .i_index      (w_indexNext),
    .i_deEnergise (w_deEnergise),
    .o_phases     (w_phases)
  );

  assign cmd.cmd_ready     = r_cmdReady;
  assign busy              = r_busy;
  assign done              = r_done;
  assign aborted           = r_aborted;
  assign line_advance_tick = r_tickAdv;
  assign line_reverse_tick = r_tickRev;
  assign motor_phase_a     = w_phases.a;
  assign motor_phase_b     = w_phases.b;
  assign motor_phase_na    = w_phases.na;
  assign motor_phase_nb    = w_phases.nb;

endmodule

// File: tb/tb_stepper_driver.sv
// Scoreboard bench for the stepper driver: each command pushes its predicted phase/pulse
// events (with the cycle they must appear on); a monitor pops and compares them.
module tb_stepper_driver;

  typedef struct {
    int         cyc;
    logic [3:0] phases;
    logic [3:0] flags;
  } event_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic energise = 1'b1;
  logic abort = 1'b0;
  logic pa, pb, pna, pnb, busy, done, aborted, tickAdv, tickRev;

  event_t     expQ[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         modelIdx = 0;
  logic [3:0] prevPhases = 4'b0000;

  stepper_driver_if cmdIf ();

  stepper_driver dut (
    .clk               (clk),
    .reset             (reset),
    .cmd               (cmdIf),
    .energise          (energise),
    .abort             (abort),
    .motor_phase_a     (pa),
    .motor_phase_b     (pb),
    .motor_phase_na    (pna),
    .motor_phase_nb    (pnb),
    .busy              (busy),
    .done              (done),
    .aborted           (aborted),
    .line_advance_tick (tickAdv),
    .line_reverse_tick (tickRev)
  );

  always #5 clk = ~clk;

  // Count rising edges so expected events can be pinned to an exact cycle.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] phaseOf(int i);
    case (i)
      0:       return 4'b1000;
      1:       return 4'b1100;
      2:       return 4'b0100;
      3:       return 4'b0110;
      4:       return 4'b0010;
      5:       return 4'b0011;
      6:       return 4'b0001;
      default: return 4'b1001;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic pushEvent(input int c, input logic [3:0] ph, input logic [3:0] fl);
    event_t e;
    e.cyc    = c;
    e.phases = ph;
    e.flags  = fl;
    expQ.push_back(e);
  endtask

  // Any phase change or pulse is an event; it must match the oldest prediction.
  always @(negedge clk) begin : monitor
    logic [3:0] ph;
    logic [3:0] fl;
    event_t     e;
    ph = {pa, pb, pna, pnb};
    fl = {tickAdv, tickRev, done, aborted};
    if ((ph !== prevPhases) || (fl != 4'b0000)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedEvent", {24'(cyc), ph, fl}, 32'(0));
      end else begin
        e = expQ.pop_front();
        checkOutput("eventCycle", 32'(cyc), 32'(e.cyc));
        checkOutput("eventPhases", 32'(ph), 32'(e.phases));
        checkOutput("eventFlags", 32'(fl), 32'(e.flags));
      end
    end
    prevPhases = ph;
  end

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_ready"}, 32'(cmdIf.cmd_ready), 32'(1));
    checkOutput({tag, "_busy"}, 32'(busy), 32'(0));
    checkOutput({tag, "_pulses"}, 32'({done, aborted, tickAdv, tickRev}), 32'(0));
  endtask

  task automatic resetDut();
    @(negedge clk);
    #2;
    reset = 1'b0;
    cmdIf.cmd_valid = 1'b0;
    expQ.delete();
    modelIdx = 0;
    if ({pa, pb, pna, pnb} != 4'b0000) pushEvent(cyc + 1, 4'b0000, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    checkOutput("resetPhases", 32'({pa, pb, pna, pnb}), 32'(0));
    checkIdle("inReset");
    reset = 1'b1;
    pushEvent(cyc + 1, phaseOf(0), 4'b0000);
    @(negedge clk);
    @(negedge clk);
    checkIdle("afterReset");
  endtask

  // Drive one command at a falling edge and predict every event it produces.
  task automatic launchMove(input logic rev, input int lines, input int period,
                            input int abortAfter, input logic hold, output int endCyc);
    int a, p, total, nSteps, waitCnt;
    logic [3:0] fl;
    waitCnt = 0;
    while (!cmdIf.cmd_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("readyBeforeCmd", 32'(cmdIf.cmd_ready), 32'(1));
    cmdIf.cmd_valid   = 1'b1;
    cmdIf.cmd_reverse = rev;
    cmdIf.cmd_lines   = 16'(lines);
    cmdIf.step_period = 24'(period);
    a = cyc + 1;
    p = (period == 0) ? 1 : period;
    if (lines == 0) begin
      endCyc = a + 1;
      pushEvent(endCyc, phaseOf(modelIdx), 4'b0010);
    end else begin
      total  = lines * 4;
      nSteps = (abortAfter >= 0) ? abortAfter : total;
      for (int k = 1; k <= nSteps; k++) begin
        modelIdx = (modelIdx + (rev ? 7 : 1)) % 8;
        fl = ((k % 4) == 0) ? (rev ? 4'b0100 : 4'b1000) : 4'b0000;
        pushEvent(a + k * p, phaseOf(modelIdx), fl);
      end
      endCyc = a + nSteps * p + 1;
      pushEvent(endCyc, phaseOf(modelIdx), (abortAfter >= 0) ? 4'b0001 : 4'b0010);
    end
    @(negedge clk);
    cmdIf.cmd_valid   = hold;
    cmdIf.cmd_reverse = ~rev;
    cmdIf.cmd_lines   = 16'd9;
    cmdIf.step_period = 24'd1;
    checkOutput("busyAfterAccept", 32'(busy), 32'(lines != 0));
    checkOutput("readyAfterAccept", 32'(cmdIf.cmd_ready), 32'(0));
  endtask

  task automatic applyStimulus(input logic rev, input int lines, input int period, input int abortAfter);
    int endCyc;
    launchMove(rev, lines, period, abortAfter, 1'b0, endCyc);
    if (abortAfter >= 0) begin
      while (cyc < endCyc - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    while (cyc < endCyc + 1) @(negedge clk);
    checkOutput("queueDrained", 32'(expQ.size()), 32'(0));
    checkIdle("afterMove");
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int endCyc;
    cmdIf.cmd_valid   = 1'b0;
    cmdIf.cmd_reverse = 1'b0;
    cmdIf.cmd_lines   = '0;
    cmdIf.step_period = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetPhases", 32'({pa, pb, pna, pnb}), 32'(0));
    checkIdle("reset");
    reset = 1'b1;
    pushEvent(cyc + 1, 4'b1000, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    checkIdle("released");

    applyStimulus(1'b0, 2, 3, -1);
    applyStimulus(1'b1, 1, 0, -1);
    applyStimulus(1'b0, 0, 5, -1);

    @(negedge clk);
    energise = 1'b0;
    pushEvent(cyc + 1, 4'b0000, 4'b0000);
    repeat (3) @(negedge clk);
    energise = 1'b1;
    pushEvent(cyc + 1, phaseOf(modelIdx), 4'b0000);
    repeat (2) @(negedge clk);

    resetDut();
    applyStimulus(1'b0, 3, 2, 5);
    applyStimulus(1'b0, 1, 2, -1);
    checkOutput("finalIndex", 32'(modelIdx), 32'(1));

    launchMove(1'b0, 2, 3, -1, 1'b1, endCyc);
    repeat (8) begin
      @(negedge clk);
      checkOutput("heldBusy", 32'(busy), 32'(1));
      checkOutput("heldReady", 32'(cmdIf.cmd_ready), 32'(0));
    end
    resetDut();
    repeat (4) @(negedge clk);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stepper_driver.md
Name: stepper_driver

Overview:
Generates the four stepper phase drive signals (a, b, na, nb) for the paper-feed motor from line-move commands. Each command gives a direction, a line count and a step period, accepted over a valid/ready handshake. The block walks the 8-state half-step sequence at 4 half-steps per dot line and pulses a per-line tick, so a bench can drive the print mechanism model and cross-check the analyser's line counts.

Parameters:
LINE_W, 16, width of cmd_lines and the lines-remaining counter
PERIOD_W, 24, width of step_period and the step timer, in clk cycles

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command (IDLE only)
cmd_reverse  in  1  0 = advance (index +1), 1 = reverse (index -1)
cmd_lines  in  LINE_W  number of dot lines to move
step_period  in  PERIOD_W  clk cycles between half-steps; 0 is treated as 1
energise  in  1  when low in IDLE, phase outputs forced to 0000
abort  in  1  synchronous stop request
motor_phase_a  out  1  phase A drive
motor_phase_b  out  1  phase B drive
motor_phase_na  out  1  phase /A drive
motor_phase_nb  out  1  phase /B drive
busy  out  1  move in progress
done  out  1  one-cycle pulse on normal completion
aborted  out  1  one-cycle pulse on abort
line_advance_tick  out  1  one-cycle pulse per completed advance line
line_reverse_tick  out  1  one-cycle pulse per completed reverse line

Behaviour:
- Half-step table, index 0..7, phases {a,b,na,nb}: 0=1000, 1=1100, 2=0100, 3=0110, 4=0010, 5=0011, 6=0001, 7=1001.
- Index arithmetic is 3-bit modulo 8: advance 7→0, reverse 0→7.
- Reset values:
  - step index 0.
  - Phases 0000, because energise is sampled from the first clock edge after reset.
  - cmd_ready 1.
  - busy, done, aborted and both ticks 0.
  - Half-step counter 0, timer 0.
- All outputs are registered.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - cmd_ready = 1.
  - Phases = table[index] if energise, else 0000.
  - On cmd_valid & cmd_ready: latch direction, lines, and max(step_period, 1).
  - cmd_lines = 0 → go to FINISH. done pulses the next cycle; phases do not change.
  - cmd_lines > 0 → go to RUN, load timer = period, clear half-step counter, busy = 1 from the next cycle.
- RUN:
  - Timer decrements each cycle.
  - When the timer reaches 1: index ±1, reload timer, half-step counter +1 (2-bit).
  - Consequence: the first phase change is exactly `period` cycles after the accept edge, and later changes are `period` cycles apart.
  - Phases are driven from the table regardless of energise.
  - When the half-step counter wraps 3→0: pulse line_advance_tick or line_reverse_tick on the same edge the phases update, and decrement lines remaining.
  - Lines remaining reaching 0 → FINISH.
- FINISH: one cycle. done = 1, busy = 0, then IDLE with cmd_ready = 1.
- abort:
  - Ignored in IDLE.
  - In RUN it takes priority over a coincident step. The index holds its current value, the partial line is discarded with no tick, aborted pulses for one cycle, and the FSM goes to IDLE. done does not pulse.
- cmd_valid while busy: ignored (cmd_ready = 0), with no effect on the move.
- Changes to step_period or cmd_* during RUN: no effect, since the values are latched.
- Asynchronous reset mid-move: all state returns to reset values immediately; no done or aborted pulse.
- Only one of line_advance_tick / line_reverse_tick is ever high, and ticks never coincide with done.

Decomposition:
- Package stepper_pkg:
  - step_t (logic [2:0]).
  - phases_t packed struct {a, b, na, nb}.
  - HALF_STEPS_PER_LINE = 4.
  - Function step_to_phases(step_t) holding the table.
  - FSM state enum.
- The same package is shared with the monitor-side decoder so the table is defined once.
- Sub-module stepper_encoder: registers step_to_phases(index), with phases forced to 0000 on a de-energise input. The top level holds the FSM, timer and counters.

Test Plan:
1. Reset; release with energise=1 → after 1 clk phases=1000, cmd_ready=1, busy=0, no pulses.
2. Advance 2 lines, period 3 → 8 phase changes 3 clks apart (1100, 0100, ... 1000); line_advance_tick on the 4th and 8th steps; done 1 clk after the 8th step; final index 0.
3. Reverse 1 line, period 0 (treated as 1) → phases 1001, 0001, 0011, 0010 on consecutive clks; one line_reverse_tick with 0010; done next clk.
4. cmd_lines=0 → done pulse 1 clk after accept; phases unchanged; no ticks; cmd_ready back the cycle after.
5. Advance 3 lines, period 2, abort after 5 steps → index 5 (0011) held; one advance tick only; aborted pulse; no done. Then advance 1 line → ends at index 1 (1100) with one tick.
6. cmd_valid held during a move, then async reset mid-move → second command not accepted during the move; after reset, outputs return to reset values with no done or aborted pulse.
